// File: rtl/ldpc_enc_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ldpc_enc_pkg
//  Purpose  : Shared constants and types for the LDPC encoder generator-matrix
//             ROM path (bank geometry, sequencer state encoding).
//  Revision : 1.0  initial release
// ============================================================================
package ldpc_enc_pkg;

  // Rows fetched per message block (depth of each generator ROM bank used)
  localparam int C_NUM_ADDR  = 19;
  // Number of parallel ROM banks sharing one address
  localparam int C_NUM_BANKS = 27;
  // Width of one row read from a single bank
  localparam int C_ROW_W     = 162;
  // Default ROM address width; 2^C_ADDR_W must cover C_NUM_ADDR
  localparam int C_ADDR_W    = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } seq_state_t;

  typedef logic [C_ADDR_W-1:0] rom_addr_t;

endpackage
`default_nettype wire

// File: rtl/g_rom_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : g_rom_sequencer
//  Purpose  : Walks the shared generator-ROM address 0..NUM_ADDR-1 once per
//             accepted message block and presents the 1-cycle-latency ROM
//             output as a valid/ready row stream with first/last markers.
//             Back-to-back blocks chain with no idle cycle; flush aborts.
//  Revision : 1.0  initial release
// ============================================================================
module g_rom_sequencer
  import ldpc_enc_pkg::*;
#(
  parameter int NUM_ADDR = C_NUM_ADDR,
  parameter int ADDR_W   = C_ADDR_W,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              msg_valid,
  output logic              msg_ready,
  output logic [ADDR_W-1:0] addra,
  output logic              row_valid,
  output logic [ADDR_W-1:0] row_idx,
  output logic              row_first,
  output logic              row_last,
  input  logic              out_ready,
  output logic              blk_done,
  output logic              busy,
  output logic [CNT_W-1:0]  blk_cnt
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_ADDR - 1);

  seq_state_t        state_q, state_d;
  logic [ADDR_W-1:0] addra_q, addra_d;
  logic [ADDR_W-1:0] row_idx_q, row_idx_d;
  logic              row_valid_q, row_valid_d;
  logic              blk_done_q, blk_done_d;
  logic [CNT_W-1:0]  blk_cnt_q, blk_cnt_d;

  logic w_issue;
  logic w_last_issue;
  logic w_row_taken;
  logic w_msg_ready;
  logic w_accept;

  // Next-state: address walk, row-valid stage, block completion and flush abort
  always_comb begin
    // A new address may be issued only when the output stage is empty or
    // being drained this cycle, so a stalled row stays on douta untouched.
    w_issue      = (state_q == RUN) && (!row_valid_q || out_ready);
    w_last_issue = w_issue && (addra_q == LAST_ADDR);
    w_row_taken  = row_valid_q && out_ready;

    w_msg_ready = 1'b0;
    if (!rst && !flush) begin
      w_msg_ready = (state_q == IDLE) || w_last_issue;
    end
    w_accept = msg_valid && w_msg_ready;

    state_d     = state_q;
    addra_d     = addra_q;
    row_idx_d   = row_idx_q;
    row_valid_d = row_valid_q;
    blk_done_d  = 1'b0;
    blk_cnt_d   = blk_cnt_q;

    if (w_issue) begin
      row_valid_d = 1'b1;
      row_idx_d   = addra_q;
    end else if (out_ready) begin
      row_valid_d = 1'b0;
    end

    if (w_row_taken && (row_idx_q == LAST_ADDR)) begin
      blk_done_d = 1'b1;
      blk_cnt_d  = blk_cnt_q + CNT_W'(1);
    end

    case (state_q)
      IDLE: begin
        if (w_accept) begin
          state_d = RUN;
          addra_d = '0;
        end
      end
      RUN: begin
        if (w_last_issue) begin
          // Wrap the address; chain straight into the next block if offered
          addra_d = '0;
          state_d = w_accept ? RUN : DRAIN;
        end else if (w_issue) begin
          addra_d = addra_q + ADDR_W'(1);
        end
      end
      DRAIN: begin
        if (w_row_taken) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        addra_d = '0;
      end
    endcase

    // Abort drops the partial block without counting it
    if (flush) begin
      state_d     = IDLE;
      addra_d     = '0;
      row_valid_d = 1'b0;
      blk_done_d  = 1'b0;
      blk_cnt_d   = blk_cnt_q;
    end
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      addra_q     <= '0;
      row_idx_q   <= '0;
      row_valid_q <= 1'b0;
      blk_done_q  <= 1'b0;
      blk_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      addra_q     <= addra_d;
      row_idx_q   <= row_idx_d;
      row_valid_q <= row_valid_d;
      blk_done_q  <= blk_done_d;
      blk_cnt_q   <= blk_cnt_d;
    end
  end

  assign msg_ready = w_msg_ready;
  assign addra     = addra_q;
  assign row_valid = row_valid_q;
  assign row_idx   = row_idx_q;
  assign row_first = row_valid_q && (row_idx_q == '0);
  assign row_last  = row_valid_q && (row_idx_q == LAST_ADDR);
  assign blk_done  = blk_done_q;
  assign busy      = (state_q != IDLE);
  assign blk_cnt   = blk_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_g_rom_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_g_rom_sequencer
//  Purpose  : Self-checking bench for g_rom_sequencer: cycle-exact single
//             block, scenario table (back-to-back, stall, flush) with a row
//             scoreboard, reset mid-block, and counter wrap on a small copy.
//  Revision : 1.0  initial release
// ============================================================================
module tb_g_rom_sequencer;

  localparam int NA = 19;
  localparam int AW = 5;
  localparam int CW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          msg_valid = 1'b0;
  logic          out_ready = 1'b1;
  logic          msg_ready, row_valid, row_first, row_last, blk_done, busy;
  logic [AW-1:0] addra, row_idx;
  logic [CW-1:0] blk_cnt;

  g_rom_sequencer #(.NUM_ADDR(NA), .ADDR_W(AW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .flush(flush), .msg_valid(msg_valid),
    .msg_ready(msg_ready), .addra(addra), .row_valid(row_valid),
    .row_idx(row_idx), .row_first(row_first), .row_last(row_last),
    .out_ready(out_ready), .blk_done(blk_done), .busy(busy), .blk_cnt(blk_cnt)
  );

  // Small copy used to exercise the completed-block counter wrap quickly
  logic       flush_w = 1'b0;
  logic       msg_valid_w = 1'b0;
  logic       out_ready_w = 1'b1;
  logic       msg_ready_w, row_valid_w, row_first_w, row_last_w, blk_done_w, busy_w;
  logic [1:0] addra_w, row_idx_w;
  logic [2:0] blk_cnt_w;

  g_rom_sequencer #(.NUM_ADDR(4), .ADDR_W(2), .CNT_W(3)) dut_w (
    .clk(clk), .rst(rst), .flush(flush_w), .msg_valid(msg_valid_w),
    .msg_ready(msg_ready_w), .addra(addra_w), .row_valid(row_valid_w),
    .row_idx(row_idx_w), .row_first(row_first_w), .row_last(row_last_w),
    .out_ready(out_ready_w), .blk_done(blk_done_w), .busy(busy_w), .blk_cnt(blk_cnt_w)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every accepted block pushes its expected row indices
  int exp_q[$];
  int rows_seen = 0, done_seen = 0, accepts = 0;
  int cyc = 0, first_cyc = 0, last_cyc = 0;
  int exp_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst && !flush) begin
      if (msg_valid && msg_ready) begin
        accepts++;
        for (int i = 0; i < NA; i++) exp_q.push_back(i);
      end
      if (row_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_row", row_idx, 999);
        end else begin
          int e;
          e = exp_q.pop_front();
          chk("sb_row_idx", row_idx, e);
          chk("sb_row_first", row_first, (e == 0));
          chk("sb_row_last", row_last, (e == NA - 1));
        end
        if (rows_seen == 0) first_cyc = cyc;
        last_cyc = cyc;
        rows_seen++;
      end
      if (blk_done) done_seen++;
    end
  end

  typedef struct {
    int nblk;
    int stall_idx;
    int stall_len;
    int flush_idx;
    int exp_rows;
    int exp_done;
    int exp_span;
  } scn_t;

  scn_t tbl[5];

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    tbl[0] = '{1, -1, 0, -1, 19, 1, 19};
    tbl[1] = '{2, -1, 0, -1, 38, 2, 38};
    tbl[2] = '{1,  5, 3, -1, 19, 1, 22};
    tbl[3] = '{1, -1, 0, 10, 10, 0, 10};
    tbl[4] = '{3, 18, 2, -1, 57, 3, 59};

    // ---------------- reset ----------------
    repeat (2) @(negedge clk);
    chk("rst_msg_ready", msg_ready, 0);
    chk("rst_addra", addra, 0);
    chk("rst_row_valid", row_valid, 0);
    chk("rst_blk_done", blk_done, 0);
    chk("rst_blk_cnt", blk_cnt, 0);
    chk("rst_busy", busy, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("idle_msg_ready", msg_ready, 1);

    // ---------------- single block, cycle exact ----------------
    @(posedge clk); #1 msg_valid = 1'b1;
    for (int c = 1; c <= 21; c++) begin
      @(posedge clk); #1;
      if (c == 1) msg_valid = 1'b0;
      @(negedge clk);
      if (c <= 19) chk("t1_addra", addra, c - 1);
      chk("t1_row_valid", row_valid, (c >= 2 && c <= 20));
      chk("t1_row_first", row_first, (c == 2));
      chk("t1_row_last", row_last, (c == 20));
      chk("t1_blk_done", blk_done, (c == 21));
      chk("t1_busy", busy, (c <= 20));
    end
    exp_cnt = 1;
    chk("t1_blk_cnt", blk_cnt, exp_cnt);
    repeat (2) @(negedge clk);

    // ---------------- scenario table ----------------
    for (int s = 0; s < 5; s++) begin
      bit stalled, flushed, flush_chk;
      int stall_left, guard;
      rows_seen = 0; done_seen = 0; accepts = 0;
      stalled = 0; flushed = 0; flush_chk = 0; stall_left = 0; guard = 0;
      @(posedge clk); #1 msg_valid = 1'b1;
      while (guard < 400) begin
        @(posedge clk); #1;
        guard++;
        if (accepts >= tbl[s].nblk) msg_valid = 1'b0;
        if (flush) begin
          flush = 1'b0;
          flush_chk = 1;
        end
        if (stall_left > 0) begin
          stall_left--;
          if (stall_left == 0) out_ready = 1'b1;
        end else if (!stalled && tbl[s].stall_idx >= 0 && row_valid &&
                     row_idx == AW'(tbl[s].stall_idx)) begin
          stalled = 1; out_ready = 1'b0; stall_left = tbl[s].stall_len;
        end else if (!flushed && tbl[s].flush_idx >= 0 && row_valid &&
                     row_idx == AW'(tbl[s].flush_idx)) begin
          flushed = 1; flush = 1'b1;
        end
        @(negedge clk); #1;
        if (!out_ready) begin
          chk("stall_row_valid", row_valid, 1);
          chk("stall_row_idx", row_idx, tbl[s].stall_idx);
          chk("stall_addra", addra, (tbl[s].stall_idx + 1) % NA);
        end
        if (flush) chk("flush_msg_ready", msg_ready, 0);
        if (flush_chk) begin
          flush_chk = 0;
          chk("flush_busy", busy, 0);
          chk("flush_row_valid", row_valid, 0);
          chk("flush_addra", addra, 0);
          chk("flush_blk_done", blk_done, 0);
          chk("flush_blk_cnt", blk_cnt, exp_cnt);
          exp_q.delete();
        end
        if (accepts >= tbl[s].nblk && !busy && exp_q.size() == 0 && !flush) break;
      end
      if (guard >= 400) chk("scn_timeout", guard, 0);
      msg_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
      repeat (2) @(negedge clk);
      exp_cnt += tbl[s].exp_done;
      chk("scn_rows", rows_seen, tbl[s].exp_rows);
      chk("scn_done", done_seen, tbl[s].exp_done);
      chk("scn_span", last_cyc - first_cyc + 1, tbl[s].exp_span);
      chk("scn_blk_cnt", blk_cnt, exp_cnt);
    end

    // ---------------- reset in the middle of a block ----------------
    begin
      int guard;
      guard = 0;
      @(posedge clk); #1 msg_valid = 1'b1;
      @(posedge clk); #1 msg_valid = 1'b0;
      while (!(row_valid && row_idx == AW'(7)) && guard < 100) begin
        @(posedge clk); #1;
        guard++;
      end
      if (guard >= 100) chk("rst_mid_timeout", guard, 0);
      rst = 1'b1;
      @(negedge clk);
      chk("rstmid_msg_ready", msg_ready, 0);
      @(posedge clk); #1 rst = 1'b0;
      exp_q.delete();
      exp_cnt = 0;
      @(negedge clk);
      chk("rstmid_addra", addra, 0);
      chk("rstmid_row_valid", row_valid, 0);
      chk("rstmid_row_idx", row_idx, 0);
      chk("rstmid_blk_done", blk_done, 0);
      chk("rstmid_blk_cnt", blk_cnt, 0);
      chk("rstmid_busy", busy, 0);
      chk("rstmid_msg_ready_after", msg_ready, 1);
    end

    // ---------------- block counter wrap (3-bit counter, 4 rows) ----------------
    begin
      int acc, dn;
      acc = 0; dn = 0;
      @(posedge clk); #1 msg_valid_w = 1'b1;
      for (int c = 0; c < 300 && dn < 9; c++) begin
        @(negedge clk);
        if (msg_valid_w && msg_ready_w) acc++;
        if (blk_done_w) begin
          dn++;
          if (dn == 8) chk("wrap_cnt_zero", blk_cnt_w, 0);
        end
        @(posedge clk); #1;
        if (acc >= 9) msg_valid_w = 1'b0;
      end
      msg_valid_w = 1'b0;
      for (int c = 0; c < 6; c++) begin
        @(negedge clk);
        if (blk_done_w) dn++;
      end
      chk("wrap_pulses", dn, 9);
      chk("wrap_cnt_final", blk_cnt_w, 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
